// File: rtl/cmp_rs_pkg.sv
// rtl/cmp_rs_pkg.sv - shared types and helpers for the compare reservation station
package cmp_rs_pkg;

    // Widest producer tag any instance may use; narrower tags are zero-extended.
    localparam int RS_TAG_W = 16;

    typedef struct packed {
        logic       cmp_signed;
        logic       cmp_64;
        logic       use_imm;
        logic [1:0] unit_sel;
    } cmp_decode_t;

    typedef enum logic [1:0] {
        RS_FREE   = 2'd0,
        RS_WAIT   = 2'd1,
        RS_READY  = 2'd2,
        RS_ISSUED = 2'd3
    } rs_entry_state_t;

    typedef struct packed {
        logic                avail;
        logic [RS_TAG_W-1:0] tag;
        logic [0:31]         value;
    } rs_operand_t;

    typedef struct packed {
        rs_entry_state_t state;
        cmp_decode_t     control;
        logic [2:0]      cr_addr;
        rs_operand_t     op1;
        rs_operand_t     op2;
        rs_operand_t     so;
    } cmp_rs_entry_t;

    // Load a pending slot from the result bus when its producer tag matches.
    function automatic rs_operand_t rs_snoop(input rs_operand_t         op,
                                             input logic                bus_valid,
                                             input logic [RS_TAG_W-1:0] bus_tag,
                                             input logic [0:31]         bus_value);
        rs_operand_t r;
        r = op;
        if (!op.avail && bus_valid && (op.tag == bus_tag)) begin
            r.avail = 1'b1;
            r.value = bus_value;
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_prio_encoder.sv
// rtl/rs_prio_encoder.sv - lowest-set-bit priority encoder (one-hot, index, any)
module rs_prio_encoder #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the lowest requesting bit is the last to win.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmp_rs.sv
// rtl/cmp_rs.sv - reservation station feeding the compare unit
module cmp_rs
    import cmp_rs_pkg::*;
#(
    parameter int RS_ENTRIES  = 4,
    parameter int RS_ID_WIDTH = 5,
    parameter int RS_OFFSET   = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   dispatch_valid,
    output logic                   dispatch_ready,
    input  cmp_decode_t            dispatch_control,
    input  logic [2:0]             dispatch_cr_addr,
    input  logic [31:0]            op1_value,
    input  logic [31:0]            op2_value,
    input  logic                   op1_avail,
    input  logic                   op2_avail,
    input  logic [RS_ID_WIDTH-1:0] op1_tag,
    input  logic [RS_ID_WIDTH-1:0] op2_tag,
    input  logic                   so_value,
    input  logic                   so_avail,
    input  logic [RS_ID_WIDTH-1:0] so_tag,
    input  logic                   res_valid,
    input  logic [RS_ID_WIDTH-1:0] res_rs_id,
    input  logic [31:0]            res_value,
    input  logic                   res_so,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [RS_ID_WIDTH-1:0] issue_rs_id,
    output logic [2:0]             issue_cr_addr,
    output logic [31:0]            issue_op1,
    output logic [31:0]            issue_op2,
    output logic                   issue_xer_so,
    output cmp_decode_t            issue_control,
    input  logic                   cr_wb_valid,
    input  logic [RS_ID_WIDTH-1:0] cr_wb_rs_id
);

    localparam int IDX_W = $clog2(RS_ENTRIES);

    cmp_rs_entry_t         entries     [RS_ENTRIES];
    cmp_rs_entry_t         entries_nxt [RS_ENTRIES];
    cmp_rs_entry_t         disp_entry;
    logic [RS_ENTRIES-1:0] free_vec;
    logic [RS_ENTRIES-1:0] ready_vec;
    logic [RS_ENTRIES-1:0] free_onehot_unused;
    logic [RS_ENTRIES-1:0] ready_oh;
    logic [IDX_W-1:0]      free_idx;
    logic [IDX_W-1:0]      ready_idx;
    logic                  free_any;
    logic                  ready_any;
    logic                  disp_fire;
    logic                  load;
    logic [RS_TAG_W-1:0]   res_tag_w;
    logic [0:31]           res_value_w;
    logic [0:31]           res_so_word;

    function automatic logic [RS_ID_WIDTH-1:0] entry_tag(input int i);
        return RS_ID_WIDTH'(RS_OFFSET + i);
    endfunction

    assign res_tag_w   = RS_TAG_W'(res_rs_id);
    assign res_value_w = res_value;
    assign res_so_word = {31'b0, res_so};

    // Per-entry occupancy views for the two selectors.
    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            free_vec[i]  = (entries[i].state == RS_FREE);
            ready_vec[i] = (entries[i].state == RS_READY);
        end
    end

    rs_prio_encoder #(.N(RS_ENTRIES), .IDX_W(IDX_W)) u_free_sel (
        .req    (free_vec),
        .onehot (free_onehot_unused),
        .idx    (free_idx),
        .any    (free_any)
    );

    rs_prio_encoder #(.N(RS_ENTRIES), .IDX_W(IDX_W)) u_ready_sel (
        .req    (ready_vec),
        .onehot (ready_oh),
        .idx    (ready_idx),
        .any    (ready_any)
    );

    assign dispatch_ready = free_any;
    assign disp_fire      = dispatch_valid && free_any;
    assign load           = (!issue_valid || issue_ready) && ready_any;

    // Build the incoming entry, letting a same-cycle result bypass into it.
    always_comb begin
        disp_entry           = '0;
        disp_entry.control   = dispatch_control;
        disp_entry.cr_addr   = dispatch_cr_addr;
        disp_entry.op1.avail = op1_avail;
        disp_entry.op1.tag   = RS_TAG_W'(op1_tag);
        disp_entry.op1.value = op1_value;
        disp_entry.op2.avail = op2_avail;
        disp_entry.op2.tag   = RS_TAG_W'(op2_tag);
        disp_entry.op2.value = op2_value;
        disp_entry.so.avail  = so_avail;
        disp_entry.so.tag    = RS_TAG_W'(so_tag);
        disp_entry.so.value  = {31'b0, so_value};
        disp_entry.op1 = rs_snoop(disp_entry.op1, res_valid, res_tag_w, res_value_w);
        disp_entry.op2 = rs_snoop(disp_entry.op2, res_valid, res_tag_w, res_value_w);
        disp_entry.so  = rs_snoop(disp_entry.so,  res_valid, res_tag_w, res_so_word);
        disp_entry.state = (disp_entry.op1.avail && disp_entry.op2.avail && disp_entry.so.avail)
                           ? RS_READY : RS_WAIT;
    end

    // Entry next-state: capture, issue, retire, allocate; flush wins over all.
    always_comb begin
        for (int i = 0; i < RS_ENTRIES; i++) begin
            entries_nxt[i] = entries[i];
            case (entries[i].state)
                RS_WAIT: begin
                    entries_nxt[i].op1 = rs_snoop(entries[i].op1, res_valid, res_tag_w, res_value_w);
                    entries_nxt[i].op2 = rs_snoop(entries[i].op2, res_valid, res_tag_w, res_value_w);
                    entries_nxt[i].so  = rs_snoop(entries[i].so,  res_valid, res_tag_w, res_so_word);
                    if (entries_nxt[i].op1.avail && entries_nxt[i].op2.avail && entries_nxt[i].so.avail) begin
                        entries_nxt[i].state = RS_READY;
                    end
                end
                RS_READY: begin
                    if (load && ready_oh[i]) begin
                        entries_nxt[i].state = RS_ISSUED;
                    end
                end
                RS_ISSUED: begin
                    if (cr_wb_valid && (cr_wb_rs_id == entry_tag(i))) begin
                        entries_nxt[i].state = RS_FREE;
                    end
                end
                default: begin
                end
            endcase
        end
        // The free index comes from current state, so a just-retired entry waits a cycle.
        if (disp_fire) begin
            entries_nxt[free_idx] = disp_entry;
        end
        if (flush) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                entries_nxt[i].state = RS_FREE;
            end
        end
    end

    // Entry storage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                entries[i] <= entries_nxt[i];
            end
        end
    end

    // Output register: reload whenever it is empty or being consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid   <= 1'b0;
            issue_rs_id   <= '0;
            issue_cr_addr <= '0;
            issue_op1     <= '0;
            issue_op2     <= '0;
            issue_xer_so  <= 1'b0;
            issue_control <= '0;
        end else if (flush) begin
            issue_valid <= 1'b0;
        end else if (load) begin
            issue_valid   <= 1'b1;
            issue_rs_id   <= RS_ID_WIDTH'(RS_OFFSET + int'(ready_idx));
            issue_cr_addr <= entries[ready_idx].cr_addr;
            issue_op1     <= entries[ready_idx].op1.value;
            issue_op2     <= entries[ready_idx].op2.value;
            issue_xer_so  <= entries[ready_idx].so.value[31];
            issue_control <= entries[ready_idx].control;
        end else if (issue_valid && issue_ready) begin
            issue_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmp_rs.sv
// tb/tb_cmp_rs.sv - self-checking bench for cmp_rs
module tb_cmp_rs;
    import cmp_rs_pkg::*;

    localparam int N   = 4;
    localparam int W   = 5;
    localparam int OFF = 0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          dispatch_valid;
    logic          dispatch_ready;
    cmp_decode_t   dispatch_control;
    logic [2:0]    dispatch_cr_addr;
    logic [31:0]   op1_value, op2_value;
    logic          op1_avail, op2_avail;
    logic [W-1:0]  op1_tag, op2_tag;
    logic          so_value, so_avail;
    logic [W-1:0]  so_tag;
    logic          res_valid;
    logic [W-1:0]  res_rs_id;
    logic [31:0]   res_value;
    logic          res_so;
    logic          issue_valid;
    logic          issue_ready;
    logic [W-1:0]  issue_rs_id;
    logic [2:0]    issue_cr_addr;
    logic [31:0]   issue_op1, issue_op2;
    logic          issue_xer_so;
    cmp_decode_t   issue_control;
    logic          cr_wb_valid;
    logic [W-1:0]  cr_wb_rs_id;

    int total = 0;
    int bad   = 0;

    cmp_rs #(.RS_ENTRIES(N), .RS_ID_WIDTH(W), .RS_OFFSET(OFF)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_control(dispatch_control), .dispatch_cr_addr(dispatch_cr_addr),
        .op1_value(op1_value), .op2_value(op2_value),
        .op1_avail(op1_avail), .op2_avail(op2_avail),
        .op1_tag(op1_tag), .op2_tag(op2_tag),
        .so_value(so_value), .so_avail(so_avail), .so_tag(so_tag),
        .res_valid(res_valid), .res_rs_id(res_rs_id), .res_value(res_value), .res_so(res_so),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rs_id(issue_rs_id),
        .issue_cr_addr(issue_cr_addr), .issue_op1(issue_op1), .issue_op2(issue_op2),
        .issue_xer_so(issue_xer_so), .issue_control(issue_control),
        .cr_wb_valid(cr_wb_valid), .cr_wb_rs_id(cr_wb_rs_id)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: instruction slots, each holding up to three operands.
    // Status codes: 0 empty, 1 waiting on operands, 2 ready, 3 sent to compare unit.
    int           m_st  [N];
    bit           m_av  [N][3];
    logic [31:0]  m_val [N][3];
    logic [W-1:0] m_tg  [N][3];
    logic [2:0]   m_cr  [N];
    cmp_decode_t  m_ctl [N];
    bit           m_ov;
    logic [W-1:0] m_id;
    logic [2:0]   m_ocr;
    logic [31:0]  m_o1, m_o2;
    bit           m_oso;
    cmp_decode_t  m_octl;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_st[i] = 0;
        m_ov = 0; m_id = '0; m_ocr = '0; m_o1 = '0; m_o2 = '0; m_oso = 0; m_octl = '0;
    endtask

    function automatic bit m_has_free();
        for (int i = 0; i < N; i++) if (m_st[i] == 0) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int           sel = -1;
        int           fre = -1;
        bit           ld;
        logic [31:0]  in_v [3];
        bit           in_a [3];
        logic [W-1:0] in_t [3];
        if (flush) begin
            for (int i = 0; i < N; i++) m_st[i] = 0;
            m_ov = 0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (sel < 0 && m_st[i] == 2) sel = i;
            if (fre < 0 && m_st[i] == 0) fre = i;
        end
        ld = (!m_ov || issue_ready) && (sel >= 0);
        for (int i = 0; i < N; i++)
            if (m_st[i] == 3 && cr_wb_valid && cr_wb_rs_id == W'(OFF + i)) m_st[i] = 0;
        for (int i = 0; i < N; i++) begin
            if (m_st[i] == 1) begin
                for (int k = 0; k < 3; k++)
                    if (!m_av[i][k] && res_valid && m_tg[i][k] == res_rs_id) begin
                        m_av[i][k]  = 1;
                        m_val[i][k] = (k == 2) ? {31'b0, res_so} : res_value;
                    end
                if (m_av[i][0] && m_av[i][1] && m_av[i][2]) m_st[i] = 2;
            end
        end
        if (m_ov && issue_ready) m_ov = 0;
        if (ld) begin
            m_ov = 1; m_id = W'(OFF + sel); m_ocr = m_cr[sel]; m_octl = m_ctl[sel];
            m_o1 = m_val[sel][0]; m_o2 = m_val[sel][1]; m_oso = m_val[sel][2][0];
            m_st[sel] = 3;
        end
        if (dispatch_valid && fre >= 0) begin
            in_v = '{op1_value, op2_value, {31'b0, so_value}};
            in_a = '{op1_avail, op2_avail, so_avail};
            in_t = '{op1_tag, op2_tag, so_tag};
            for (int k = 0; k < 3; k++) begin
                m_av[fre][k] = in_a[k]; m_val[fre][k] = in_v[k]; m_tg[fre][k] = in_t[k];
                if (!in_a[k] && res_valid && in_t[k] == res_rs_id) begin
                    m_av[fre][k]  = 1;
                    m_val[fre][k] = (k == 2) ? {31'b0, res_so} : res_value;
                end
            end
            m_cr[fre] = dispatch_cr_addr; m_ctl[fre] = dispatch_control;
            m_st[fre] = (m_av[fre][0] && m_av[fre][1] && m_av[fre][2]) ? 2 : 1;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_eq("issue_valid",    64'(issue_valid),    64'(m_ov));
        check_eq("dispatch_ready", 64'(dispatch_ready), 64'(m_has_free()));
        check_eq("issue_rs_id",    64'(issue_rs_id),    64'(m_id));
        check_eq("issue_cr_addr",  64'(issue_cr_addr),  64'(m_ocr));
        check_eq("issue_op1",      64'(issue_op1),      64'(m_o1));
        check_eq("issue_op2",      64'(issue_op2),      64'(m_o2));
        check_eq("issue_xer_so",   64'(issue_xer_so),   64'(m_oso));
        check_eq("issue_control",  64'(issue_control),  64'(m_octl));
    endtask

    task automatic idle();
        flush = 0; dispatch_valid = 0; dispatch_control = '0; dispatch_cr_addr = '0;
        op1_value = '0; op2_value = '0; op1_avail = 1; op2_avail = 1; so_avail = 1;
        op1_tag = '0; op2_tag = '0; so_tag = '0; so_value = 0;
        res_valid = 0; res_rs_id = '0; res_value = '0; res_so = 0;
        cr_wb_valid = 0; cr_wb_rs_id = '0;
    endtask

    task automatic disp(input logic [31:0] a, input logic [31:0] b, input logic so,
                        input logic a_av, input logic [W-1:0] a_tag,
                        input logic b_av, input logic [W-1:0] b_tag, input logic [2:0] cr);
        idle();
        dispatch_valid = 1; dispatch_cr_addr = cr; dispatch_control = cmp_decode_t'(5'(cr) + 5'd1);
        op1_value = a; op2_value = b; so_value = so;
        op1_avail = a_av; op1_tag = a_tag; op2_avail = b_av; op2_tag = b_tag;
    endtask

    task automatic retire(input int idx);
        idle(); cr_wb_valid = 1; cr_wb_rs_id = W'(OFF + idx); cycle();
    endtask

    task automatic rand_cycle();
        int pick;
        dispatch_valid   = ($urandom_range(0, 99) < 50);
        dispatch_control = cmp_decode_t'(5'($urandom));
        dispatch_cr_addr = 3'($urandom);
        op1_value = $urandom; op2_value = $urandom; so_value = 1'($urandom);
        op1_avail = ($urandom_range(0, 99) < 60);
        op2_avail = ($urandom_range(0, 99) < 60);
        so_avail  = ($urandom_range(0, 99) < 70);
        op1_tag = W'($urandom_range(8, 13)); op2_tag = W'($urandom_range(8, 13));
        so_tag  = W'($urandom_range(8, 13));
        res_valid = 1'($urandom); res_rs_id = W'($urandom_range(8, 13));
        res_value = $urandom; res_so = 1'($urandom);
        issue_ready = ($urandom_range(0, 99) < 70);
        flush = ($urandom_range(0, 99) < 2);
        cr_wb_valid = ($urandom_range(0, 99) < 40);
        pick = $urandom_range(0, N - 1);
        cr_wb_rs_id = (m_st[pick] == 3 || $urandom_range(0, 3) == 0) ? W'(OFF + pick)
                                                                      : W'($urandom_range(0, 31));
        cycle();
    endtask

    initial begin
        idle();
        issue_ready = 1;
        rst_n = 0;
        model_reset();
        #3;
        check_eq("rst_issue_valid",    64'(issue_valid),    64'd0);
        check_eq("rst_dispatch_ready", 64'(dispatch_ready), 64'd1);
        check_eq("rst_issue_op1",      64'(issue_op1),      64'd0);
        @(negedge clk);
        rst_n = 1;

        // Basic all-available dispatch: valid two edges later.
        disp(32'd5, 32'd7, 1'b1, 1, '0, 1, '0, 3'd3);
        so_avail = 1;
        cycle();
        check_eq("t1_edge1_valid", 64'(issue_valid), 64'd0);
        idle(); cycle();
        check_eq("t1_valid", 64'(issue_valid),  64'd1);
        check_eq("t1_id",    64'(issue_rs_id),  64'(OFF));
        check_eq("t1_op1",   64'(issue_op1),    64'd5);
        check_eq("t1_op2",   64'(issue_op2),    64'd7);
        check_eq("t1_so",    64'(issue_xer_so), 64'd1);
        check_eq("t1_cr",    64'(issue_cr_addr), 64'd3);
        idle(); cycle();
        retire(0);

        // Late capture from the result bus.
        disp(32'd0, 32'd2, 1'b0, 0, W'(9), 1, '0, 3'd1);
        cycle();
        idle(); res_valid = 1; res_rs_id = W'(9); res_value = 32'hFFFF_FFFF; cycle();
        check_eq("t2_wait_valid", 64'(issue_valid), 64'd0);
        idle(); cycle();
        check_eq("t2_cap_valid", 64'(issue_valid), 64'd1);
        check_eq("t2_cap_op1",   64'(issue_op1),   64'hFFFF_FFFF);
        idle(); cycle();
        retire(0);

        // Dispatch bypass from the same-cycle bus.
        disp(32'd3, 32'd0, 1'b0, 1, '0, 0, W'(9), 3'd2);
        res_valid = 1; res_rs_id = W'(9); res_value = 32'h0000_1234;
        cycle();
        idle(); cycle();
        check_eq("t2_byp_valid", 64'(issue_valid), 64'd1);
        check_eq("t2_byp_op2",   64'(issue_op2),   64'h1234);
        idle(); cycle();
        retire(0);

        // Fill every entry, retire entry 2, reallocate it.
        for (int i = 0; i < N; i++) begin
            disp(32'(i + 100), 32'(i), 1'b0, 1, '0, 1, '0, 3'(i));
            cycle();
        end
        check_eq("t3_full", 64'(dispatch_ready), 64'd0);
        idle();
        for (int i = 0; i < 4; i++) cycle();
        retire(2);
        check_eq("t3_freed", 64'(dispatch_ready), 64'd1);
        disp(32'hAAAA, 32'd1, 1'b1, 1, '0, 1, '0, 3'd6);
        cycle();
        idle(); cycle();
        check_eq("t3_realloc_id", 64'(issue_rs_id), 64'(OFF + 2));
        idle(); cycle();
        for (int i = 0; i < N; i++) retire(i);

        // Back-pressure holds outputs, then back-to-back issue.
        issue_ready = 0;
        disp(32'h11, 32'd1, 1'b0, 1, '0, 1, '0, 3'd0); cycle();
        disp(32'h22, 32'd2, 1'b1, 1, '0, 1, '0, 3'd1); cycle();
        idle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("t4_hold_id",  64'(issue_rs_id), 64'(OFF));
            check_eq("t4_hold_op1", 64'(issue_op1),   64'h11);
        end
        issue_ready = 1; cycle();
        check_eq("t4_next_valid", 64'(issue_valid), 64'd1);
        check_eq("t4_next_id",    64'(issue_rs_id), 64'(OFF + 1));
        idle(); cycle();
        retire(0); retire(1);

        // Flush with a waiting entry and a pending output.
        issue_ready = 0;
        disp(32'd1, 32'd1, 1'b0, 1, '0, 1, '0, 3'd0); cycle();
        disp(32'd0, 32'd1, 1'b0, 0, W'(12), 1, '0, 3'd0); cycle();
        check_eq("t5_pre_valid", 64'(issue_valid), 64'd1);
        disp(32'd9, 32'd9, 1'b0, 1, '0, 1, '0, 3'd0); flush = 1; cycle();
        check_eq("t5_flush_valid", 64'(issue_valid),    64'd0);
        check_eq("t5_flush_ready", 64'(dispatch_ready), 64'd1);
        issue_ready = 1;
        idle(); res_valid = 1; res_rs_id = W'(12); res_value = 32'h5; cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("t5_no_issue", 64'(issue_valid), 64'd0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) rand_cycle();

        // Asynchronous reset in the middle of traffic.
        #2;
        rst_n = 0;
        #1;
        check_eq("t6_valid",   64'(issue_valid),    64'd0);
        check_eq("t6_ready",   64'(dispatch_ready), 64'd1);
        check_eq("t6_id",      64'(issue_rs_id),    64'd0);
        check_eq("t6_op1",     64'(issue_op1),      64'd0);
        check_eq("t6_op2",     64'(issue_op2),      64'd0);
        check_eq("t6_so",      64'(issue_xer_so),   64'd0);
        check_eq("t6_cr",      64'(issue_cr_addr),  64'd0);
        check_eq("t6_control", 64'(issue_control),  64'd0);
        model_reset();
        idle();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 300; i++) rand_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
